// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: PRGA state encoding, memory geometry and the default printable range.
package rc4_pkg;

    localparam int BYTE_W    = 8;
    localparam int MEM_DEPTH = 256;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);

    // Printable window shared with the crack/display logic
    localparam logic [BYTE_W-1:0] DEF_PRINT_LO = 8'h20;
    localparam logic [BYTE_W-1:0] DEF_PRINT_HI = 8'h7E;

    typedef enum logic [3:0] {
        IDLE,
        RDL,
        LATL,
        WRL,
        RDI,
        LATI,
        RDJ,
        LATJ,
        WRI,
        WRJ,
        RDP,
        WRP
    } state_t;

endpackage

// File: rtl/prga.sv
// RC4 PRGA stage: walks S for the keystream and XORs it into a length-prefixed plaintext buffer.
// Optional printable tracking on pt_ok is enabled by defining PRGA_PRINT_CHECK_EN.
module prga
    import rc4_pkg::*;
`ifdef PRGA_PRINT_CHECK_EN
#(
    parameter logic [BYTE_W-1:0] PRINT_LO = DEF_PRINT_LO,
    parameter logic [BYTE_W-1:0] PRINT_HI = DEF_PRINT_HI
)
`endif
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    output logic [ADDR_W-1:0] s_addr,
    input  logic [BYTE_W-1:0] s_rddata,
    output logic [BYTE_W-1:0] s_wrdata,
    output logic              s_wren,
    output logic [ADDR_W-1:0] ct_addr,
    input  logic [BYTE_W-1:0] ct_rddata,
    output logic [ADDR_W-1:0] pt_addr,
    output logic [BYTE_W-1:0] pt_wrdata,
    output logic              pt_wren,
    output logic              pt_ok
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] i_reg, i_next;
    logic [ADDR_W-1:0] j_reg, j_next;
    logic [ADDR_W-1:0] k_reg, k_next;
    logic [BYTE_W-1:0] len_reg, len_next;
    logic [BYTE_W-1:0] si_reg, si_next;
    logic [BYTE_W-1:0] sj_reg, sj_next;
    logic [BYTE_W-1:0] ctb_reg, ctb_next;
    logic [BYTE_W-1:0] pad_byte;

    // Only meaningful in WRP, when s_rddata carries S[si+sj]
    assign pad_byte = s_rddata ^ ctb_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            len_reg   <= '0;
            si_reg    <= '0;
            sj_reg    <= '0;
            ctb_reg   <= '0;
        end else begin
            state_reg <= state_next;
            i_reg     <= i_next;
            j_reg     <= j_next;
            k_reg     <= k_next;
            len_reg   <= len_next;
            si_reg    <= si_next;
            sj_reg    <= sj_next;
            ctb_reg   <= ctb_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        i_next     = i_reg;
        j_next     = j_reg;
        k_next     = k_reg;
        len_next   = len_reg;
        si_next    = si_reg;
        sj_next    = sj_reg;
        ctb_next   = ctb_reg;
        rdy        = 1'b0;
        s_addr     = '0;
        s_wrdata   = '0;
        s_wren     = 1'b0;
        ct_addr    = '0;
        pt_addr    = '0;
        pt_wrdata  = '0;
        pt_wren    = 1'b0;
        case (state_reg)
            IDLE: begin
                rdy = 1'b1;
                if (en) state_next = RDL;
            end
            RDL: begin
                ct_addr    = '0;
                state_next = LATL;
            end
            LATL: begin
                len_next   = ct_rddata;
                i_next     = '0;
                j_next     = '0;
                k_next     = 8'd1;
                state_next = WRL;
            end
            WRL: begin
                pt_addr    = '0;
                pt_wrdata  = len_reg;
                pt_wren    = 1'b1;
                state_next = (len_reg == '0) ? IDLE : RDI;
            end
            RDI: begin
                i_next     = i_reg + 8'd1;
                s_addr     = i_reg + 8'd1;
                ct_addr    = k_reg;
                state_next = LATI;
            end
            LATI: begin
                si_next    = s_rddata;
                ctb_next   = ct_rddata;
                j_next     = j_reg + s_rddata;
                state_next = RDJ;
            end
            RDJ: begin
                s_addr     = j_reg;
                state_next = LATJ;
            end
            LATJ: begin
                sj_next    = s_rddata;
                state_next = WRI;
            end
            // When i==j the second write lands last with si, which equals sj anyway
            WRI: begin
                s_addr     = i_reg;
                s_wrdata   = sj_reg;
                s_wren     = 1'b1;
                state_next = WRJ;
            end
            WRJ: begin
                s_addr     = j_reg;
                s_wrdata   = si_reg;
                s_wren     = 1'b1;
                state_next = RDP;
            end
            RDP: begin
                s_addr     = si_reg + sj_reg;
                state_next = WRP;
            end
            WRP: begin
                pt_addr   = k_reg;
                pt_wrdata = pad_byte;
                pt_wren   = 1'b1;
                if (k_reg == len_reg) begin
                    state_next = IDLE;
                end else begin
                    k_next     = k_reg + 8'd1;
                    state_next = RDI;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef PRGA_PRINT_CHECK_EN
    logic ok_reg;

    // Re-armed on each accepted start; the length header is never judged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_reg <= 1'b1;
        end else if (state_reg == IDLE && en) begin
            ok_reg <= 1'b1;
        end else if (state_reg == WRP && (pad_byte < PRINT_LO || pad_byte > PRINT_HI)) begin
            ok_reg <= 1'b0;
        end
    end

    assign pt_ok = ok_reg;
`else
    assign pt_ok = 1'b1;
`endif

endmodule
